sign_applier: RTL and testbench

Result-side counterpart of the PPU sign decision. Takes the unsigned posit magnitude produced by the core datapath plus the result sign and special-case flags, and emits the final two's-complement posit word. It is a 2-stage valid/ready pipeline with full backpressure support, and it sits between the arithmetic core and the PPU output port.

---
 rtl/ppu_pkg.sv | 12 +
 rtl/sign_applier_if.sv | 24 ++
 rtl/pipe_stage.sv | 23 ++
 rtl/sign_applier.sv | 66 ++++++
 tb/tb_sign_applier.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared posit-unit types, special-case codes and width-generic constants
package ppu_pkg;
  localparam int MAX_N = 64;
  typedef enum logic [1:0] {ADD, SUB, MUL, DIV} operation_e;
  typedef enum logic [1:0] {SP_NORMAL, SP_ZERO, SP_NAR} special_e;
  function automatic logic [MAX_N-1:0] ppu_nar(input int n);
    return MAX_N'(1) << (n - 1);
  endfunction
  function automatic logic [MAX_N-1:0] maxpos(input int n);
    return (MAX_N'(1) << (n - 1)) - MAX_N'(1);
  endfunction
endpackage

// File: rtl/sign_applier_if.sv
// sign_applier_if: magnitude-in / signed-posit-out valid/ready bundle
interface sign_applier_if #(parameter int N = 16);
  import ppu_pkg::*;
  logic in_valid_i;
  logic in_ready_o;
  logic sign_i;
  logic [N-1:0] mag_i;
  logic is_zero_i;
  logic is_nar_i;
  operation_e op_i;
  logic out_valid_o;
  logic out_ready_i;
  logic [N-1:0] posit_o;
  operation_e op_o;
  logic sat_o;
  modport master(
    output in_valid_i, sign_i, mag_i, is_zero_i, is_nar_i, op_i, out_ready_i,
    input in_ready_o, out_valid_o, posit_o, op_o, sat_o
  );
  modport slave(
    input in_valid_i, sign_i, mag_i, is_zero_i, is_nar_i, op_i, out_ready_i,
    output in_ready_o, out_valid_o, posit_o, op_o, sat_o
  );
endinterface

// File: rtl/pipe_stage.sv
// pipe_stage: one valid/ready register slice with a generic payload type
module pipe_stage #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
endmodule

// File: rtl/sign_applier.sv
// sign_applier: resolves NaR/zero/saturation and applies the result sign
// over a two-slice valid/ready pipeline.
module sign_applier
  import ppu_pkg::*;
#(
  parameter int N = 16
) (
  input logic clk_i,
  input logic rst_i,
  sign_applier_if.slave bus
);
  localparam logic [MAX_N-1:0] NAR_W = ppu_nar(N);
  localparam logic [MAX_N-1:0] MAX_W = maxpos(N);
  localparam logic [N-1:0] NAR = NAR_W[N-1:0];
  localparam logic [N-1:0] MAXP = MAX_W[N-1:0];
  typedef struct packed {
    logic neg;
    logic [N-1:0] mag;
    special_e sp;
    logic sat;
    operation_e op;
  } s1_t;
  typedef struct packed {
    logic [N-1:0] posit;
    logic sat;
    operation_e op;
  } s2_t;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  special_e sp_c;
  logic sat_c, s1_valid, s1_ready;
  logic [N-1:0] signed_mag;
  // NaR outranks zero, which outranks the out-of-range clamp
  assign sp_c = bus.is_nar_i ? SP_NAR : bus.is_zero_i ? SP_ZERO : SP_NORMAL;
  assign sat_c = sp_c == SP_NORMAL && bus.mag_i[N-1];
  assign s1_d = '{neg: bus.sign_i, mag: sat_c ? MAXP : bus.mag_i, sp: sp_c, sat: sat_c, op: bus.op_i};
  pipe_stage #(.T(s1_t)) u_s1 (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .in_valid(bus.in_valid_i),
    .in_ready(bus.in_ready_o),
    .in_data(s1_d),
    .out_valid(s1_valid),
    .out_ready(s1_ready),
    .out_data(s1_q)
  );
  assign signed_mag = s1_q.neg ? -s1_q.mag : s1_q.mag;
  assign s2_d = '{
    posit: s1_q.sp == SP_NAR ? NAR : s1_q.sp == SP_ZERO ? {N{1'b0}} : signed_mag,
    sat: s1_q.sat,
    op: s1_q.op
  };
  pipe_stage #(.T(s2_t)) u_s2 (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .in_valid(s1_valid),
    .in_ready(s1_ready),
    .in_data(s2_d),
    .out_valid(bus.out_valid_o),
    .out_ready(bus.out_ready_i),
    .out_data(s2_q)
  );
  assign bus.posit_o = s2_q.posit;
  assign bus.sat_o = s2_q.sat;
  assign bus.op_o = s2_q.op;
endmodule

// File: tb/tb_sign_applier.sv
// tb_sign_applier: directed and randomized checks of sign_applier against a reference model
module tb_sign_applier;
  import ppu_pkg::*;
  typedef struct packed {
    logic [15:0] p;
    operation_e op;
    logic sat;
  } exp_t;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  sign_applier_if #(.N(16)) bus();
  sign_applier #(.N(16)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [15:0] m, input logic z, input logic n,
                                 input operation_e o);
    int v;
    model.op = o;
    model.sat = !n && !z && m >= 16'h8000;
    if (n) v = 32768;
    else if (z) v = 0;
    else begin
      v = model.sat ? 32767 : int'(m);
      if (s) v = (65536 - v) % 65536;
    end
    model.p = 16'(v);
  endfunction

  always @(negedge clk_i) begin : scoreboard
    exp_t e;
    if (!rst_i) begin
      if (bus.in_valid_i && bus.in_ready_o)
        q.push_back(model(bus.sign_i, bus.mag_i, bus.is_zero_i, bus.is_nar_i, bus.op_i));
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (q.size() == 0) check("sb_extra", 1, 0);
        else begin
          e = q.pop_front();
          check("sb_posit", 32'(bus.posit_o), 32'(e.p));
          check("sb_op", 32'(bus.op_o), 32'(e.op));
          check("sb_sat", 32'(bus.sat_o), 32'(e.sat));
        end
      end
    end
  end

  task automatic drive(input logic v, input logic s, input logic [15:0] m, input logic z,
                       input logic n, input operation_e o);
    bus.in_valid_i = v;
    bus.sign_i = s;
    bus.mag_i = m;
    bus.is_zero_i = z;
    bus.is_nar_i = n;
    bus.op_i = o;
  endtask

  task automatic send_one(input string tag, input logic s, input logic [15:0] m, input logic z,
                          input logic n, input operation_e o, input logic [15:0] ep, input logic es);
    drive(1'b1, s, m, z, n, o);
    bus.out_ready_i = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(bus.in_ready_o), 1);
    @(posedge clk_i); #1;
    bus.in_valid_i = 1'b0;
    check({tag, "_lat1"}, 32'(bus.out_valid_o), 0);
    @(posedge clk_i); #1;
    check({tag, "_vld"}, 32'(bus.out_valid_o), 1);
    check({tag, "_posit"}, 32'(bus.posit_o), 32'(ep));
    check({tag, "_sat"}, 32'(bus.sat_o), 32'(es));
    check({tag, "_op"}, 32'(bus.op_o), 32'(o));
    @(posedge clk_i); #1;
    check({tag, "_gone"}, 32'(bus.out_valid_o), 0);
  endtask

  task automatic rand_beat();
    drive($urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom), $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0, operation_e'($urandom_range(0, 3)));
  endtask

  initial begin
    logic took;
    int idx;
    logic [15:0] bp_exp[4];
    operation_e bp_op[4];
    bp_exp = '{'hFFFF, 'hFFFE, 'hFFFD, 'hFFFC};
    bp_op = '{ADD, SUB, MUL, DIV};
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, ADD);
    bus.out_ready_i = 1'b0;
    #1;
    check("rst_valid", 32'(bus.out_valid_o), 0);
    check("rst_posit", 32'(bus.posit_o), 0);
    check("rst_sat", 32'(bus.sat_o), 0);
    check("rst_op", 32'(bus.op_o), 32'(ADD));
    check("rst_ready", 32'(bus.in_ready_o), 1);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("post_rst_ready", 32'(bus.in_ready_o), 1);

    send_one("neg", 1'b1, 'h1234, 1'b0, 1'b0, SUB, 'hEDCC, 1'b0);
    send_one("pos", 1'b0, 'h1234, 1'b0, 1'b0, ADD, 'h1234, 1'b0);
    send_one("zero", 1'b1, 'h5555, 1'b1, 1'b0, MUL, 'h0000, 1'b0);
    send_one("nar", 1'b1, 'h5555, 1'b1, 1'b1, DIV, 'h8000, 1'b0);
    send_one("satn", 1'b1, 'h8001, 1'b0, 1'b0, ADD, 'h8001, 1'b1);
    send_one("satp", 1'b0, 'h8001, 1'b0, 1'b0, SUB, 'h7FFF, 1'b1);

    idx = 0;
    bus.out_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 4) drive(1'b1, 1'b1, 16'(idx + 1), 1'b0, 1'b0, bp_op[idx]);
      else bus.in_valid_i = 1'b0;
      #1;
      took = bus.in_valid_i && bus.in_ready_o;
      @(posedge clk_i); #1;
      if (took) idx++;
      if (c >= 1) check("bp_hold", 32'(bus.posit_o), 'hFFFF);
    end
    check("bp_accepts", idx, 2);
    check("bp_ready_low", 32'(bus.in_ready_o), 0);
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (idx < 4) drive(1'b1, 1'b1, 16'(idx + 1), 1'b0, 1'b0, bp_op[idx]);
      else bus.in_valid_i = 1'b0;
      #1;
      took = bus.in_valid_i && bus.in_ready_o;
      check("bp_valid", 32'(bus.out_valid_o), 1);
      check("bp_seq", 32'(bus.posit_o), 32'(bp_exp[k]));
      check("bp_op", 32'(bus.op_o), 32'(bp_op[k]));
      @(posedge clk_i); #1;
      if (took) idx++;
    end
    bus.in_valid_i = 1'b0;
    check("bp_drained", 32'(bus.out_valid_o), 0);

    took = 1'b0;
    for (int c = 0; c < 500; c++) begin
      bus.out_ready_i = $urandom_range(0, 3) != 0;
      if (!bus.in_valid_i || took) rand_beat();
      #1;
      took = bus.in_valid_i && bus.in_ready_o;
      @(posedge clk_i); #1;
    end
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    check("sb_empty", q.size(), 0);

    bus.out_ready_i = 1'b0;
    drive(1'b1, 1'b1, 'h0100, 1'b0, 1'b0, SUB);
    @(posedge clk_i); #1;
    drive(1'b1, 1'b0, 'h0200, 1'b0, 1'b0, MUL);
    @(posedge clk_i); #1;
    bus.in_valid_i = 1'b0;
    check("mid_full", 32'(bus.out_valid_o), 1);
    #2;
    rst_i = 1'b1;
    q.delete();
    #1;
    check("async_valid", 32'(bus.out_valid_o), 0);
    check("async_posit", 32'(bus.posit_o), 0);
    check("async_sat", 32'(bus.sat_o), 0);
    check("async_op", 32'(bus.op_o), 32'(ADD));
    check("async_ready", 32'(bus.in_ready_o), 1);
    @(posedge clk_i);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("rel_ready", 32'(bus.in_ready_o), 1);
    check("rel_valid", 32'(bus.out_valid_o), 0);
    send_one("after_rst", 1'b0, 'h0010, 1'b0, 1'b0, MUL, 'h0010, 1'b0);
    check("after_rst_sb", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
